// File: rtl/board_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : board_input_conditioner
// Purpose  : Board reset sequencer plus switch/button synchroniser, inverter
//            and debouncer. Optional edge pulses: BOARD_INPUT_COND_EDGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module board_input_conditioner #(
    parameter int unsigned      NumSw          = 13,
    parameter logic [NumSw-1:0] InvertMask     = '1,
    parameter int unsigned      DebounceCycles = 50000,
    parameter int unsigned      PorDelayCycles = 5,
    parameter int unsigned      PorHoldCycles  = 195
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_i,
    input  logic             rst_btn_ni,
    input  logic [NumSw-1:0] sw_i,
    output logic [NumSw-1:0] sw_o,
    output logic [NumSw-1:0] sw_rise_o,
    output logic [NumSw-1:0] sw_fall_o,
    output logic             rst_req_o,
    output logic             por_done_o
);

    localparam int unsigned c_db_w   = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
    localparam int unsigned c_por_max = (PorDelayCycles > PorHoldCycles) ? PorDelayCycles
                                                                         : PorHoldCycles;
    localparam int unsigned c_cnt_w  = $clog2(c_por_max + 1);

    localparam logic [c_db_w-1:0]  c_db_last   = c_db_w'(DebounceCycles - 1);
    localparam logic [c_db_w-1:0]  c_db_one    = c_db_w'(1);
    localparam logic [c_cnt_w-1:0] c_delay     = c_cnt_w'(PorDelayCycles);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(PorHoldCycles - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_BTN  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Switch channels: synchroniser, polarity fix-up and debounce
    // ------------------------------------------------------------------
    logic [NumSw-1:0]  r_sw_meta;
    logic [NumSw-1:0]  r_sw_sync;
    logic [NumSw-1:0]  r_sw_stable;
    logic [c_db_w-1:0] r_sw_cnt [NumSw];
    logic [NumSw-1:0]  w_sw_act;
    logic [NumSw-1:0]  w_sw_flip;

    assign w_sw_act = r_sw_sync ^ InvertMask;

    // A channel flips on the cycle its counter has seen enough disagreeing samples.
    always_comb begin
        w_sw_flip = '0;
        for (int i = 0; i < NumSw; i++) begin
            w_sw_flip[i] = (w_sw_act[i] != r_sw_stable[i]) && (r_sw_cnt[i] == c_db_last);
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_sw_meta   <= InvertMask;
            r_sw_sync   <= InvertMask;
            r_sw_stable <= '0;
            for (int i = 0; i < NumSw; i++) begin
                r_sw_cnt[i] <= '0;
            end
        end else begin
            r_sw_meta   <= sw_i;
            r_sw_sync   <= r_sw_meta;
            r_sw_stable <= r_sw_stable ^ w_sw_flip;
            for (int i = 0; i < NumSw; i++) begin
                if ((w_sw_act[i] == r_sw_stable[i]) || w_sw_flip[i]) begin
                    r_sw_cnt[i] <= '0;
                end else begin
                    r_sw_cnt[i] <= r_sw_cnt[i] + c_db_one;
                end
            end
        end
    end

    assign sw_o = r_sw_stable;

`ifdef BOARD_INPUT_COND_EDGE_EN
    logic [NumSw-1:0] r_sw_rise;
    logic [NumSw-1:0] r_sw_fall;

    // Pulses are registered alongside the stable value so they line up with sw_o.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_sw_rise <= '0;
            r_sw_fall <= '0;
        end else begin
            r_sw_rise <= w_sw_flip & w_sw_act;
            r_sw_fall <= w_sw_flip & ~w_sw_act;
        end
    end

    assign sw_rise_o = r_sw_rise;
    assign sw_fall_o = r_sw_fall;
`else
    assign sw_rise_o = '0;
    assign sw_fall_o = '0;
`endif

    // ------------------------------------------------------------------
    // Reset button: synchronised, always active-low, same debounce rule
    // ------------------------------------------------------------------
    logic              r_btn_meta;
    logic              r_btn_sync;
    logic              r_btn_stable;
    logic [c_db_w-1:0] r_btn_cnt;
    logic              w_btn_act;
    logic              w_btn_flip;

    assign w_btn_act  = ~r_btn_sync;
    assign w_btn_flip = (w_btn_act != r_btn_stable) && (r_btn_cnt == c_db_last);

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_btn_meta   <= 1'b1;
            r_btn_sync   <= 1'b1;
            r_btn_stable <= 1'b0;
            r_btn_cnt    <= '0;
        end else begin
            r_btn_meta   <= rst_btn_ni;
            r_btn_sync   <= r_btn_meta;
            r_btn_stable <= r_btn_stable ^ w_btn_flip;
            if ((w_btn_act == r_btn_stable) || w_btn_flip) begin
                r_btn_cnt <= '0;
            end else begin
                r_btn_cnt <= r_btn_cnt + c_db_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reset sequencer: OFF -> HOLD -> RUN, button press detours via BTN
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_rst_req;
    logic               r_por_done;

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_state    <= ST_OFF;
            r_cnt      <= '0;
            r_rst_req  <= 1'b0;
            r_por_done <= 1'b0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (r_cnt == c_delay) begin
                        r_state   <= ST_HOLD;
                        r_cnt     <= '0;
                        r_rst_req <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == c_hold_last) begin
                        r_state    <= ST_RUN;
                        r_cnt      <= '0;
                        r_rst_req  <= 1'b0;
                        r_por_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                ST_RUN: begin
                    if (r_btn_stable) begin
                        r_state   <= ST_BTN;
                        r_rst_req <= 1'b1;
                    end
                end
                ST_BTN: begin
                    // Release re-enters HOLD so a short press still gets a full window.
                    if (!r_btn_stable) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state   <= ST_OFF;
                    r_cnt     <= '0;
                    r_rst_req <= 1'b0;
                end
            endcase
        end
    end

    assign rst_req_o  = r_rst_req;
    assign por_done_o = r_por_done;

endmodule
`default_nettype wire
